// File: rtl/count_arbiter_if.sv
// Handshake bundle between two counting requesters and count_arbiter.
// Requester side drives REQ/DIR/STEPS; the arbiter drives grants and status.
interface count_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             REQ_A;
  logic             DIR_A;
  logic [WIDTH-1:0] STEPS_A;
  logic             REQ_B;
  logic             DIR_B;
  logic [WIDTH-1:0] STEPS_B;
  logic             GNT_A;
  logic             GNT_B;
  logic             DONE_A;
  logic             DONE_B;
  logic             BUSY;
  logic [WIDTH-1:0] COUNT_OUT;

  modport master (
    output REQ_A, DIR_A, STEPS_A,
    output REQ_B, DIR_B, STEPS_B,
    input  GNT_A, GNT_B,
    input  DONE_A, DONE_B,
    input  BUSY, COUNT_OUT
  );

  modport slave (
    input  REQ_A, DIR_A, STEPS_A,
    input  REQ_B, DIR_B, STEPS_B,
    output GNT_A, GNT_B,
    output DONE_A, DONE_B,
    output BUSY, COUNT_OUT
  );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin arbiter granting a shared up/down counter to one of two
// requesters for a latched number of steps.
module count_arbiter #(
  parameter int WIDTH = 4
) (
  input logic          CLOCK,
  input logic          RESET_N,
  count_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] remaining;
  logic             dir;
  logic             owner;
  logic             last;
  logic             req_any;
  logic             pick;
  logic             dir_sel;
  logic [WIDTH-1:0] steps_sel;

  // owner/last/pick: 0 = requester A, 1 = requester B
  always_comb begin
    req_any   = bus.REQ_A | bus.REQ_B;
    pick      = (bus.REQ_A & bus.REQ_B) ? ~last : bus.REQ_B;
    dir_sel   = pick ? bus.DIR_B : bus.DIR_A;
    steps_sel = pick ? bus.STEPS_B : bus.STEPS_A;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_any)
          state_nxt = (steps_sel != '0) ? RUN : FINISH;
      end
      RUN: begin
        if (remaining == WIDTH'(1))
          state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count     <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            owner     <= pick;
            dir       <= dir_sel;
            remaining <= steps_sel;
          end
        end
        RUN: begin
          count     <= dir ? count + WIDTH'(1)
                           : count - WIDTH'(1);
          remaining <= remaining - WIDTH'(1);
        end
        FINISH:  last <= owner;
        default: ;
      endcase
    end
  end

  assign bus.BUSY      = (state != IDLE);
  assign bus.GNT_A     = bus.BUSY & ~owner;
  assign bus.GNT_B     = bus.BUSY & owner;
  assign bus.DONE_A    = (state == FINISH) & ~owner;
  assign bus.DONE_B    = (state == FINISH) & owner;
  assign bus.COUNT_OUT = count;

endmodule

// File: tb/tb_count_arbiter.sv
// Randomised self-checking bench for count_arbiter against a
// transaction-level model of grant order and counter trajectory.
module tb_count_arbiter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic CLOCK = 1'b0;
  logic RESET_N;

  count_arbiter_if #(.WIDTH(W)) bus ();

  count_arbiter #(.WIDTH(W)) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int m_count;
  bit m_last;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.REQ_A   = 1'b0;
    bus.REQ_B   = 1'b0;
    bus.DIR_A   = 1'b0;
    bus.DIR_B   = 1'b0;
    bus.STEPS_A = '0;
    bus.STEPS_B = '0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_gnt_a"}, 32'(bus.GNT_A), 0);
    chk({tag, "_gnt_b"}, 32'(bus.GNT_B), 0);
    chk({tag, "_done_a"}, 32'(bus.DONE_A), 0);
    chk({tag, "_done_b"}, 32'(bus.DONE_B), 0);
    chk({tag, "_busy"}, 32'(bus.BUSY), 0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    clear_inputs();
    RESET_N = 1'b0;
    #1;
    check_quiet("rst");
    chk("rst_count", 32'(bus.COUNT_OUT), 0);
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    m_count = 0;
    m_last  = 1'b1;
  endtask

  function automatic int wrap(input int v);
    return ((v % M) + M) % M;
  endfunction

  // One complete transaction: request, grant, N steps, done, back to idle.
  task automatic run(input bit ra, input bit rb,
                     input bit da, input bit db,
                     input int sa, input int sb,
                     input bit perturb, input bit hold);
    bit win;
    bit d;
    int n;
    int start;
    int exp_c;
    @(negedge CLOCK);
    bus.REQ_A   = ra;
    bus.REQ_B   = rb;
    bus.DIR_A   = da;
    bus.DIR_B   = db;
    bus.STEPS_A = W'(sa);
    bus.STEPS_B = W'(sb);
    win   = (ra && rb) ? !m_last : rb;
    d     = win ? db : da;
    n     = win ? sb : sa;
    start = m_count;
    exp_c = start;
    chk("pre_busy", 32'(bus.BUSY), 0);
    @(posedge CLOCK);
    #1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(negedge CLOCK);
        if (perturb) begin
          bus.DIR_A   = 1'($urandom_range(0, 1));
          bus.DIR_B   = 1'($urandom_range(0, 1));
          bus.STEPS_A = W'($urandom_range(0, M - 1));
          bus.STEPS_B = W'($urandom_range(0, M - 1));
        end
        @(posedge CLOCK);
        #1;
      end
      exp_c = wrap(start + (d ? k : -k));
      chk("run_count", 32'(bus.COUNT_OUT), 32'(exp_c));
      chk("run_gnt_a", 32'(bus.GNT_A), 32'(!win));
      chk("run_gnt_b", 32'(bus.GNT_B), 32'(win));
      chk("run_busy", 32'(bus.BUSY), 1);
      chk("run_done_a", 32'(bus.DONE_A), 32'(k == n && !win));
      chk("run_done_b", 32'(bus.DONE_B), 32'(k == n && win));
    end
    if (!hold) begin
      bus.REQ_A = 1'b0;
      bus.REQ_B = 1'b0;
    end
    @(posedge CLOCK);
    #1;
    check_quiet("idle");
    chk("idle_count", 32'(bus.COUNT_OUT), 32'(exp_c));
    m_count = exp_c;
    m_last  = win;
  endtask

  initial begin
    RESET_N = 1'b0;
    clear_inputs();
    do_reset();

    run(1, 0, 1, 0, 5, 0, 0, 0);
    chk("up5_final", 32'(bus.COUNT_OUT), 5);
    run(1, 0, 0, 0, 4, 0, 0, 0);
    run(0, 1, 0, 0, 0, 3, 0, 0);
    chk("wrap_final", 32'(bus.COUNT_OUT), 14);
    run(1, 0, 1, 0, 0, 0, 0, 0);
    chk("zero_final", 32'(bus.COUNT_OUT), 14);
    run(1, 0, 1, 0, 3, 0, 0, 0);
    chk("wrap_up_final", 32'(bus.COUNT_OUT), 1);

    do_reset();
    run(1, 1, 1, 0, 3, 2, 0, 1);
    run(1, 1, 1, 0, 3, 2, 0, 1);
    run(1, 1, 0, 1, 1, 4, 0, 1);
    run(1, 1, 1, 1, 2, 0, 0, 0);

    run(1, 0, 0, 1, 6, 2, 1, 0);
    run(0, 1, 1, 1, 9, 7, 1, 0);

    @(negedge CLOCK);
    bus.REQ_A   = 1'b1;
    bus.DIR_A   = 1'b1;
    bus.STEPS_A = W'(8);
    repeat (3) @(posedge CLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    check_quiet("midrst");
    chk("midrst_count", 32'(bus.COUNT_OUT), 0);
    bus.REQ_A = 1'b0;
    repeat (2) begin
      @(posedge CLOCK);
      #1;
      check_quiet("midrst_hold");
    end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    m_count = 0;
    m_last  = 1'b1;
    run(1, 1, 0, 1, 2, 3, 0, 0);

    for (int i = 0; i < 24; i++) begin
      bit ra;
      bit rb;
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      run(ra, rb,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, M - 1)),
          int'($urandom_range(0, M - 1)),
          1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the shared counter and of the STEPS_A/STEPS_B fields.
REQ-002 CLOCK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 REQ_A  input  1  requester A asks for a counting run; held high until DONE_A is seen.
REQ-005 DIR_A  input  1  requester A direction: 1 = up, 0 = down; sampled only at grant.
REQ-006 STEPS_A  input  WIDTH  requester A step count; sampled only at grant.
REQ-007 REQ_B, DIR_B, STEPS_B  input  1/1/WIDTH  same meaning for requester B.
REQ-008 GNT_A, GNT_B  output  1  requester owns the counter; never both high.
REQ-009 DONE_A, DONE_B  output  1  one-cycle pulse: the owner's run has completed.
REQ-010 BUSY  output  1  high whenever the FSM is not IDLE.
REQ-011 COUNT_OUT  output  WIDTH  current value of the shared counter register.

Function
REQ-012 The block SHALL contain one WIDTH-bit counter register and an FSM with states IDLE, RUN and FINISH.
REQ-013 IDLE: at an edge with REQ_A or REQ_B high, the block SHALL select one requester, latch its DIR and STEPS into internal registers, and set its GNT; the next state is RUN if the latched STEPS != 0, otherwise FINISH.
REQ-014 Arbitration SHALL be round-robin via a last-served pointer: if both requests are high, the requester not served last wins; a single request wins regardless of the pointer.
REQ-015 RUN: at each edge the counter SHALL step by +1 (latched DIR = 1) or -1 (latched DIR = 0) and the remaining count SHALL decrement; at the edge where remaining reaches 0 the state SHALL go to FINISH.
REQ-016 A run of N steps SHALL therefore change COUNT_OUT on exactly N consecutive edges, the first being the edge after the grant edge.
REQ-017 Counter arithmetic SHALL be modulo 2^WIDTH: (2^WIDTH)-1 + 1 -> 0 and 0 - 1 -> (2^WIDTH)-1, with no flag and no stall.
REQ-018 FINISH: the owner's GNT and DONE SHALL both be high for exactly one cycle, the counter SHALL hold, and the last-served pointer SHALL be set to the owner; the next state is IDLE.
REQ-019 IDLE: GNT_A, GNT_B, DONE_A and DONE_B SHALL be low and the counter SHALL hold its value between runs (no auto-clear).
REQ-020 REQ, DIR and STEPS changes during RUN or FINISH SHALL be ignored; a run always completes once granted (no abort).
REQ-021 The earliest re-grant SHALL be at the first IDLE edge after FINISH, so there is at least one cycle with BUSY low between back-to-back runs.
REQ-022 All outputs SHALL be driven from registers or from decode of the FSM state only, with no combinational path from inputs.

Reset
REQ-023 While RESET_N is low, the following SHALL hold immediately (without waiting for a clock edge): state IDLE, COUNT_OUT = 0, remaining = 0, latched DIR = 0, last-served pointer = B (so A wins the first contention), and GNT_A = GNT_B = DONE_A = DONE_B = BUSY = 0.
REQ-024 Reset asserted mid-run SHALL abandon the run with no DONE pulse; after release the block SHALL accept requests from the first rising edge.

Verification
REQ-025 From reset, REQ_A = 1, DIR_A = 1, STEPS_A = 5 -> GNT_A high from the edge after the request; COUNT_OUT goes 1,2,3,4,5 on 5 consecutive edges; then one cycle with DONE_A = 1 and GNT_A = 1; then IDLE.
REQ-026 COUNT_OUT = 1, REQ_B = 1, DIR_B = 0, STEPS_B = 3 -> COUNT_OUT goes 0,15,14 (WIDTH = 4), DONE_B pulses once, and COUNT_OUT holds 14 afterward.
REQ-027 REQ_A and REQ_B both high from reset and held -> grant order A, B, A, B with one BUSY-low cycle between runs; GNT_A and GNT_B never overlap.
REQ-028 STEPS_A = 0 -> grant edge goes directly to FINISH; DONE_A pulses on the next cycle and COUNT_OUT is unchanged.
REQ-029 RESET_N pulsed low during cycle 2 of an 8-step run -> outputs go to reset values immediately; no DONE pulse; a new request after release is granted normally.
REQ-030 DIR_A and STEPS_A toggled during RUN -> the run uses the values latched at grant, verified by the final COUNT_OUT.
